// File: rtl/attn_pkg.sv
// Shared definitions for the attention output path: default widths, the packed
// row entry layout and the round/saturate quantizer used by the row packer.
package attn_pkg;

  localparam int IN_W    = 18;
  localparam int OUT_W   = 8;
  localparam int ROW_LEN = 8;
  localparam int ROWS    = 8;
  localparam int IDX_W   = $clog2(ROWS);

  typedef struct packed {
    logic [ROW_LEN*OUT_W-1:0] data;
    logic [IDX_W-1:0]         idx;
    logic [OUT_W-1:0]         max;
  } row_entry_t;

  // The extra top bit keeps the rounding add from wrapping at full-scale input.
  function automatic logic [OUT_W-1:0] round_sat(input logic [IN_W-1:0] x,
                                                 input int unsigned     shift);
    logic [IN_W:0] s;
    s = {1'b0, x} + ((IN_W+1)'(1) << (shift - 1));
    s = s >> shift;
    if (|s[IN_W:OUT_W]) return '1;
    return s[OUT_W-1:0];
  endfunction

endpackage

// File: rtl/attn_row_fifo.sv
// Synchronous FIFO for packed row entries; a pop frees space for a push in the
// same cycle, so a full FIFO can accept a write while its head drains.
module attn_row_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = mem_q[rd_q];

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    if (do_push) wr_d = (wr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_q + PTR_W'(1);
    if (do_pop)  rd_d = (rd_q == PTR_W'(DEPTH - 1)) ? '0 : rd_q + PTR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: the count alone decides what is visible.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/attention_row_packer.sv
// Quantizes the attention core's 8x8 output stream, packs each row with its
// maximum and hands rows downstream over valid/ready through a row FIFO.
module attention_row_packer
  import attn_pkg::*;
#(
  parameter int IN_W       = attn_pkg::IN_W,
  parameter int OUT_W      = attn_pkg::OUT_W,
  parameter int SHIFT      = 6,
  parameter int ROW_LEN    = attn_pkg::ROW_LEN,
  parameter int ROWS       = attn_pkg::ROWS,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     done_in,
  input  logic [IN_W-1:0]          answer_in,
  output logic                     row_valid,
  input  logic                     row_ready,
  output logic [ROW_LEN*OUT_W-1:0] row_data,
  output logic [$clog2(ROWS)-1:0]  row_idx,
  output logic [OUT_W-1:0]         row_max,
  output logic                     frame_done,
  output logic                     overflow
);

  localparam int COL_W   = $clog2(ROW_LEN);
  localparam int ROW_W   = $clog2(ROWS);
  localparam int CNT_W   = COL_W + ROW_W;
  localparam int DATA_W  = ROW_LEN * OUT_W;
  localparam int ENTRY_W = DATA_W + ROW_W + OUT_W;
  localparam logic [IN_W:0] ROUND = (IN_W+1)'(1) << (SHIFT - 1);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IN_W:0]      sum_w, shr_w;
  logic [OUT_W-1:0]   q_w;
  logic               s1_valid_q;
  logic [OUT_W-1:0]   s1_val_q;
  logic [COL_W-1:0]   s1_col_q;
  logic [ROW_W-1:0]   s1_row_q;
  logic [DATA_W-1:0]  asm_q, asm_d;
  logic [OUT_W-1:0]   max_q, max_d;
  logic               row_done_q;
  logic [ROW_W-1:0]   row_done_idx_q;
  logic               ent_valid_q;
  logic [ENTRY_W-1:0] ent_q;
  logic               ovf_q;
  logic [ENTRY_W-1:0] head_w;
  logic               fifo_full, fifo_empty, pop_w;

  assign sum_w = {1'b0, answer_in} + ROUND;
  assign shr_w = sum_w >> SHIFT;
  assign q_w   = (|shr_w[IN_W:OUT_W]) ? '1 : shr_w[OUT_W-1:0];

  // Column 0 restarts the running max so each row's max stands alone.
  always_comb begin
    cnt_d = cnt_q;
    asm_d = asm_q;
    max_d = max_q;
    if (done_in) cnt_d = cnt_q + CNT_W'(1);
    if (s1_valid_q) begin
      asm_d[s1_col_q*OUT_W +: OUT_W] = s1_val_q;
      if (s1_col_q == '0 || s1_val_q > max_q) max_d = s1_val_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q          <= '0;
      s1_valid_q     <= 1'b0;
      s1_val_q       <= '0;
      s1_col_q       <= '0;
      s1_row_q       <= '0;
      asm_q          <= '0;
      max_q          <= '0;
      row_done_q     <= 1'b0;
      row_done_idx_q <= '0;
      ent_valid_q    <= 1'b0;
      ent_q          <= '0;
      ovf_q          <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      s1_valid_q <= done_in;
      if (done_in) begin
        s1_val_q <= q_w;
        s1_col_q <= cnt_q[COL_W-1:0];
        s1_row_q <= cnt_q[COL_W +: ROW_W];
      end
      asm_q          <= asm_d;
      max_q          <= max_d;
      row_done_q     <= s1_valid_q && (s1_col_q == COL_W'(ROW_LEN - 1));
      row_done_idx_q <= s1_row_q;
      // The completed row is captured before the next row's column 0 lands.
      ent_valid_q    <= row_done_q;
      if (row_done_q) ent_q <= {asm_q, row_done_idx_q, max_q};
      if (ent_valid_q && fifo_full && !pop_w) ovf_q <= 1'b1;
    end
  end

  attn_row_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (ent_valid_q),
    .pop_i   (pop_w),
    .din_i   (ent_q),
    .dout_o  (head_w),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign row_valid  = !fifo_empty;
  assign pop_w      = row_valid && row_ready;
  assign row_data   = row_valid ? head_w[ENTRY_W-1 -: DATA_W] : '0;
  assign row_idx    = row_valid ? head_w[OUT_W +: ROW_W] : '0;
  assign row_max    = row_valid ? head_w[OUT_W-1:0] : '0;
  assign frame_done = pop_w && (head_w[OUT_W +: ROW_W] == ROW_W'(ROWS - 1));
  assign overflow   = ovf_q;

endmodule
